masked_bitwise_dom: RTL and testbench
=====================================

Name: masked_bitwise_dom

Overview:
Parametrised d-th order Boolean-masked bitwise unit, successor to the fixed 2-share bitwise masking wrapper in the masked ALU datapath.
- Operands arrive as N = D+1 Boolean shares; result leaves as N shares.
- Supports NOT, XOR, AND, IOR, MASK and REMASK.
- AND and IOR use a pipelined domain-oriented-masking (DOM) multiplier with fresh randomness.
- Valid/ready handshake; operands are held by the issuer until ready pulses.

Parameters:
XLEN, 32, width of one share word
D, 1, masking order (supported values 1..3)
N, D+1, share count (derived; do not override)
L, D*(D+1)/2, number of XLEN-bit random words per operation (derived)

Ports:
g_clk  in  1  clock
g_resetn  in  1  synchronous active-low reset
valid  in  1  request; held high with op/operands stable until ready
flush  in  1  synchronous abort of the in-flight operation
op  in  3  0 NOT, 1 XOR, 2 AND, 3 IOR, 4 MASK, 5 REMASK, 6-7 reserved
rs1_sh  in  N*XLEN  operand 1 shares; share i at [i*XLEN +: XLEN]
rs2_sh  in  N*XLEN  operand 2 shares
rnd  in  L*XLEN  fresh random words; word k at [k*XLEN +: XLEN]
prng_update  in  1  advance internal PRNG (used only with the optional feature)
ready  out  1  one-cycle pulse: rd_sh valid
rd_sh  out  N*XLEN  result shares (registered)

Behaviour:
- Reset (g_resetn=0 at posedge): state IDLE, ready=0, rd_sh=0, DOM pipeline registers=0.
- States:
  - IDLE: if valid is high, decode op and sample rnd. Linear/reserved ops go to DONE. AND/IOR go to MUL.
  - MUL: register DOM partial products, then go to DONE.
  - DONE: ready=1 for exactly one cycle, then go to IDLE.
- Latency from valid sampled in IDLE to ready: NOT/XOR/MASK/REMASK/reserved 1 cycle; AND/IOR 2 cycles.
- If valid stays high in the IDLE cycle after DONE, a new operation starts.
- rd_sh holds its value between operations until overwritten, flushed or reset.
- NOT: rd share 0 = ~rs1 share 0; all other shares pass through.
- XOR: share-wise rs1_i ^ rs2_i.
- AND (DOM), MUL stage registers:
  - Inner terms a_i&b_i.
  - For each pair i<j using random word k (pairs enumerated lexicographically), the cross terms (a_i&b_j)^r_k and (a_j&b_i)^r_k.
  - DONE stage compresses each domain: rd_i = XOR of all terms registered in domain i.
  - No combinational path mixes shares before the MUL register.
- IOR: computed as ~(~a & ~b). Invert share 0 of both operands, run the AND path, invert share 0 of the result.
- MASK: rs1 share 0 is the plain value. rd_i = rnd word i for i<N-1; rd_{N-1} = rs1_s0 ^ XOR of those words. rs2 and the other rs1 shares are ignored.
- REMASK: rd_i = rs1_i ^ rnd_i for i<N-1; rd_{N-1} = rs1_{N-1} ^ XOR of rnd_0..rnd_{N-2}. The unmasked value is unchanged.
- MASK and REMASK only need N-1 random words; L >= D always holds.
- Reserved op: rd_sh = 0, ready after 1 cycle.
- Flush (flush=1 at posedge, g_resetn=1): from any state go to IDLE, ready=0, rd_sh=0, pipeline cleared. Flush takes priority over valid in the same cycle. Reset takes priority over flush.
- Reset mid-operation behaves like flush; no ready is issued for the aborted op.
- rnd is sampled only in the IDLE accept cycle; later changes have no effect on the current op.

Optional Feature:
MASKED_BITWISE_PRNG_EN
- Defined:
  - L internal 32-bit xorshift generators (XLEN-wide via replication/concatenation) supply the random words; the rnd port is ignored.
  - Generators are seeded with distinct non-zero constants at reset.
  - They advance one step on each cycle where prng_update=1, and additionally on every accepted operation.
- Not defined: randomness comes only from the rnd port; prng_update is ignored. No generator logic is present.

Test Plan:
- D=1, op=NOT, rs1 shares 0x0484D609/0x31F05663 -> ready 1 cycle after valid; rd_s0^rd_s1 = 0xCA8B7F95.
- D=1, op=AND, same rs1, rs2 shares 0/0, rnd=0xA5A5A5A5 -> ready exactly 2 cycles after valid; unmasked result 0x00000000; repeat with rs2=0xFFFF0000/0x0000FFFF -> 0x3574806A.
- D=1, op=MASK, rs1_s0=0xDEADBEEF, rnd=0x12345678 -> rd_s0=0x12345678, rd_s1=0xCC99E897; op=REMASK with the same input -> unmasked result 0xDEADBEEF.
- D=1, op=IOR, valid asserted, flush pulsed in MUL -> no ready pulse, rd_sh=0. The next IOR with rs1=0x3574806A (two shares), rs2=0 completes with 0x3574806A.
- D=2 and D=3: 1000 random ops per opcode with random rnd each cycle -> XOR of all rd shares equals the plain reference. No X on rd_sh when ready=1; latency 1 (linear) or 2 (AND/IOR) every time.
- Reset asserted mid-AND, then back-to-back ops with valid held high -> ready=0 and rd_sh=0 after reset; consecutive ready pulses are separated by one IDLE cycle.

Source files
------------

// File: rtl/masked_bitwise_dom.sv
// d-th order Boolean-masked bitwise unit: NOT/XOR/MASK/REMASK in one cycle, AND/IOR via DOM in two.
// Optional feature macro MASKED_BITWISE_PRNG_EN: internal xorshift generators replace the rnd port.

module masked_bitwise_dom #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned D    = 1,
  parameter int unsigned N    = D + 1,
  parameter int unsigned L    = D * (D + 1) / 2
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                valid,
  input  logic                flush,
  input  logic [2:0]          op,
  input  logic [N*XLEN-1:0]   rs1_sh,
  input  logic [N*XLEN-1:0]   rs2_sh,
  input  logic [L*XLEN-1:0]   rnd,
  input  logic                prng_update,
  output logic                ready,
  output logic [N*XLEN-1:0]   rd_sh
);

  localparam logic [2:0] OpNot    = 3'd0;
  localparam logic [2:0] OpXor    = 3'd1;
  localparam logic [2:0] OpAnd    = 3'd2;
  localparam logic [2:0] OpIor    = 3'd3;
  localparam logic [2:0] OpMask   = 3'd4;
  localparam logic [2:0] OpRemask = 3'd5;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e            state_q, state_d;
  logic              ior_q, ior_d;
  logic [N*XLEN-1:0] rd_q, rd_d;
  logic [N*XLEN-1:0] rd_lin, rd_mul;
  logic [XLEN-1:0]   term_q   [N][N];
  logic [XLEN-1:0]   term_d   [N][N];
  logic [XLEN-1:0]   term_new [N][N];
  logic [XLEN-1:0]   s1 [N];
  logic [XLEN-1:0]   s2 [N];
  logic [XLEN-1:0]   a  [N];
  logic [XLEN-1:0]   b  [N];
  logic [XLEN-1:0]   r  [L];
  logic [XLEN-1:0]   acc;
  logic              is_ior;
  logic              accept;

  assign is_ior = (op == OpIor);

  // IOR runs as ~(~a & ~b): only share 0 carries the inversion.
  for (genvar i = 0; i < N; i++) begin : g_share
    assign s1[i] = rs1_sh[i*XLEN +: XLEN];
    assign s2[i] = rs2_sh[i*XLEN +: XLEN];
    if (i == 0) begin : g_inv
      assign a[i] = is_ior ? ~s1[i] : s1[i];
      assign b[i] = is_ior ? ~s2[i] : s2[i];
    end else begin : g_pass
      assign a[i] = s1[i];
      assign b[i] = s2[i];
    end
  end

  // Row i holds every term belonging to domain i; cross terms are blinded before registering.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (i == j) begin : g_inner
        assign term_new[i][j] = a[i] & b[j];
      end else begin : g_cross
        localparam int unsigned Lo = (i < j) ? i : j;
        localparam int unsigned Hi = (i < j) ? j : i;
        localparam int unsigned K  = Lo * N - (Lo * (Lo + 1)) / 2 + (Hi - Lo - 1);
        assign term_new[i][j] = (a[i] & b[j]) ^ r[K];
      end
    end
  end

`ifdef MASKED_BITWISE_PRNG_EN
  logic [31:0] prng_q [L];
  logic [31:0] prng_d [L];
  logic        unused_rnd;

  assign unused_rnd = ^rnd;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always_comb begin
    for (int k = 0; k < L; k++) begin
      prng_d[k] = (prng_update || accept) ? xorshift32(prng_q[k]) : prng_q[k];
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      for (int k = 0; k < L; k++) begin
        prng_q[k] <= 32'h9E37_79B9 + 32'(k) * 32'h0100_0193;
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        prng_q[k] <= prng_d[k];
      end
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_rnd
    for (genvar bt = 0; bt < XLEN; bt++) begin : g_bit
      assign r[k][bt] = prng_q[k][bt % 32];
    end
  end
`else
  logic unused_prng;

  assign unused_prng = prng_update;

  for (genvar k = 0; k < L; k++) begin : g_rnd
    assign r[k] = rnd[k*XLEN +: XLEN];
  end
`endif

  always_comb begin
    acc = '0;
    for (int i = 0; i < N - 1; i++) begin
      acc = acc ^ r[i];
    end
    rd_lin = '0;
    case (op)
      OpNot: begin
        for (int i = 0; i < N; i++) begin
          rd_lin[i*XLEN +: XLEN] = s1[i];
        end
        rd_lin[XLEN-1:0] = ~s1[0];
      end
      OpXor: begin
        for (int i = 0; i < N; i++) begin
          rd_lin[i*XLEN +: XLEN] = s1[i] ^ s2[i];
        end
      end
      OpMask: begin
        for (int i = 0; i < N - 1; i++) begin
          rd_lin[i*XLEN +: XLEN] = r[i];
        end
        rd_lin[(N-1)*XLEN +: XLEN] = s1[0] ^ acc;
      end
      OpRemask: begin
        for (int i = 0; i < N - 1; i++) begin
          rd_lin[i*XLEN +: XLEN] = s1[i] ^ r[i];
        end
        rd_lin[(N-1)*XLEN +: XLEN] = s1[N-1] ^ acc;
      end
      default: rd_lin = '0;
    endcase
  end

  // Compression only touches registered terms, so shares never meet before the pipeline register.
  always_comb begin
    rd_mul = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        rd_mul[i*XLEN +: XLEN] = rd_mul[i*XLEN +: XLEN] ^ term_q[i][j];
      end
    end
    if (ior_q) begin
      rd_mul[XLEN-1:0] = ~rd_mul[XLEN-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    ior_d   = ior_q;
    term_d  = term_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          accept = 1'b1;
          if (op == OpAnd || op == OpIor) begin
            state_d = StMul;
            term_d  = term_new;
            ior_d   = is_ior;
          end else begin
            state_d = StDone;
            rd_d    = rd_lin;
          end
        end
      end
      StMul: begin
        rd_d    = rd_mul;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      rd_d    = '0;
      ior_d   = 1'b0;
      accept  = 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          term_d[i][j] = '0;
        end
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      rd_q    <= '0;
      ior_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          term_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      ior_q   <= ior_d;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          term_q[i][j] <= term_d[i][j];
        end
      end
    end
  end

  assign ready = (state_q == StDone);
  assign rd_sh = rd_q;

endmodule

// File: tb/tb_masked_bitwise_dom.sv
// Bench for masked_bitwise_dom: D=1,2,3 instances share one stimulus stream, checked against
// an unmasked reference and the share rules for the linear ops.

module tb_masked_bitwise_dom;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic         flush;
  logic         prng_update;
  logic [2:0]   op;
  logic [127:0] rs1;
  logic [127:0] rs2;
  logic [191:0] rnd;
  logic         rdy1, rdy2, rdy3;
  logic [63:0]  rd1;
  logic [95:0]  rd2;
  logic [127:0] rd3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  masked_bitwise_dom #(.XLEN(32), .D(1)) u_dut_d1 (
    .g_clk(clk), .g_resetn(rst_n), .valid(valid), .flush(flush), .op(op),
    .rs1_sh(rs1[63:0]), .rs2_sh(rs2[63:0]), .rnd(rnd[31:0]), .prng_update(prng_update),
    .ready(rdy1), .rd_sh(rd1)
  );

  masked_bitwise_dom #(.XLEN(32), .D(2)) u_dut_d2 (
    .g_clk(clk), .g_resetn(rst_n), .valid(valid), .flush(flush), .op(op),
    .rs1_sh(rs1[95:0]), .rs2_sh(rs2[95:0]), .rnd(rnd[95:0]), .prng_update(prng_update),
    .ready(rdy2), .rd_sh(rd2)
  );

  masked_bitwise_dom #(.XLEN(32), .D(3)) u_dut_d3 (
    .g_clk(clk), .g_resetn(rst_n), .valid(valid), .flush(flush), .op(op),
    .rs1_sh(rs1), .rs2_sh(rs2), .rnd(rnd), .prng_update(prng_update),
    .ready(rdy3), .rd_sh(rd3)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sh(input logic [127:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic logic [31:0] rw(input logic [191:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic logic [31:0] unmask(input logic [127:0] v, input int n);
    logic [31:0] x = '0;
    for (int i = 0; i < n; i++) x ^= sh(v, i);
    return x;
  endfunction

  // Plain-value reference: what the op means once all shares are folded together.
  function automatic logic [31:0] ref_plain(input int n, input logic [2:0] o,
                                            input logic [127:0] a, input logic [127:0] b);
    logic [31:0] pa = unmask(a, n);
    logic [31:0] pb = unmask(b, n);
    case (o)
      3'd0:    return ~pa;
      3'd1:    return pa ^ pb;
      3'd2:    return pa & pb;
      3'd3:    return pa | pb;
      3'd4:    return sh(a, 0);
      3'd5:    return pa;
      default: return 32'h0;
    endcase
  endfunction

  // Exact share layout for the deterministic (non-DOM) ops.
  function automatic logic [127:0] ref_shares(input int n, input logic [2:0] o,
                                              input logic [127:0] a, input logic [127:0] b,
                                              input logic [191:0] r);
    logic [127:0] e = '0;
    logic [31:0]  s = '0;
    for (int i = 0; i < n - 1; i++) s ^= rw(r, i);
    for (int i = 0; i < n; i++) begin
      case (o)
        3'd0: e[i*32 +: 32] = (i == 0) ? ~sh(a, 0) : sh(a, i);
        3'd1: e[i*32 +: 32] = sh(a, i) ^ sh(b, i);
        3'd4: e[i*32 +: 32] = (i == n - 1) ? (sh(a, 0) ^ s) : rw(r, i);
        3'd5: e[i*32 +: 32] = (i == n - 1) ? (sh(a, i) ^ s) : (sh(a, i) ^ rw(r, i));
        default: e[i*32 +: 32] = 32'h0;
      endcase
    end
    return e;
  endfunction

  function automatic logic [127:0] rd_of(input int n);
    case (n)
      2:       return {64'h0, rd1};
      3:       return {32'h0, rd2};
      default: return rd3;
    endcase
  endfunction

  function automatic logic [191:0] rand192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called one step after a rising edge with the DUTs idle (or in DONE when extra_lat=1).
  task automatic do_op(input logic [2:0] o, input logic [127:0] a, input logic [127:0] b,
                       input logic [191:0] r, input int extra_lat, input bit keep_valid,
                       input string tag);
    int lat;
    int exp_lat;
    bit seen;
    logic [127:0] got;
    lat     = 0;
    seen    = 1'b0;
    exp_lat = ((o == 3'd2 || o == 3'd3) ? 2 : 1) + extra_lat;
    op    = o;
    rs1   = a;
    rs2   = b;
    rnd   = r;
    valid = 1'b1;
    while (!seen && lat < 6) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == extra_lat + 1) rnd = rand192();
      if (rdy1 | rdy2 | rdy3) seen = 1'b1;
    end
    check_eq({tag, "/lat"}, 128'(lat), 128'(exp_lat));
    check_eq({tag, "/rdy"}, {125'h0, rdy3, rdy2, rdy1}, 128'h7);
    for (int n = 2; n <= 4; n++) begin
      got = rd_of(n);
      check_eq({tag, "/x"}, 128'($isunknown(got)), 128'h0);
      check_eq({tag, "/val"}, 128'(unmask(got, n)), 128'(ref_plain(n, o, a, b)));
      if (o != 3'd2 && o != 3'd3) check_eq({tag, "/sh"}, got, ref_shares(n, o, a, b, r));
    end
    if (!keep_valid) begin
      valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_quiet(input string tag);
    check_eq({tag, "/rdy"}, {125'h0, rdy3, rdy2, rdy1}, 128'h0);
    for (int n = 2; n <= 4; n++) check_eq({tag, "/rd"}, rd_of(n), 128'h0);
  endtask

  initial begin
    logic [127:0] hold;
    rst_n       = 1'b0;
    valid       = 1'b0;
    flush       = 1'b0;
    prng_update = 1'b0;
    op          = 3'd0;
    rs1         = '0;
    rs2         = '0;
    rnd         = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors; extra shares of wider instances are zero so all share the plain value.
    do_op(3'd0, {64'h0, 32'h31F05663, 32'h0484D609}, '0, rand192(), 0, 0, "not");
    check_eq("not/d1", 128'(unmask(rd_of(2), 2)), 128'hCA8B7F95);
    do_op(3'd2, {64'h0, 32'h31F05663, 32'h0484D609}, '0,
          {rand192() >> 32, 32'hA5A5A5A5}, 0, 0, "and0");
    check_eq("and0/d1", 128'(unmask(rd_of(2), 2)), 128'h0);
    do_op(3'd2, {64'h0, 32'h31F05663, 32'h0484D609}, {64'h0, 32'h0000FFFF, 32'hFFFF0000},
          {rand192() >> 32, 32'hA5A5A5A5}, 0, 0, "and1");
    check_eq("and1/d1", 128'(unmask(rd_of(2), 2)), 128'h3574806A);
    do_op(3'd4, {96'h0, 32'hDEADBEEF}, rand128(), {rand192() >> 32, 32'h12345678}, 0, 0, "mask");
    check_eq("mask/d1", rd_of(2), {64'h0, 32'hCC99E897, 32'h12345678});
    hold = rd_of(2);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold/d1", rd_of(2), hold);
    do_op(3'd5, {96'h0, 32'hDEADBEEF}, rand128(), {rand192() >> 32, 32'h12345678}, 0, 0, "remask");
    check_eq("remask/d1", 128'(unmask(rd_of(2), 2)), 128'hDEADBEEF);

    // Flush while in MUL: no ready, results cleared.
    op    = 3'd3;
    rs1   = rand128();
    rs2   = rand128();
    rnd   = rand192();
    valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    expect_quiet("flush_mul");
    repeat (2) begin
      @(posedge clk);
      #1;
      expect_quiet("flush_after");
    end
    do_op(3'd3, {64'h0, 32'h3574806A ^ 32'h5A5A1234, 32'h5A5A1234}, '0, rand192(), 0, 0, "ior");
    check_eq("ior/d1", 128'(unmask(rd_of(2), 2)), 128'h3574806A);

    // Flush beats valid in the same IDLE cycle.
    op    = 3'd1;
    rs1   = rand128();
    rs2   = rand128();
    valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid = 1'b0;
    expect_quiet("flush_prio");
    @(posedge clk);
    #1;
    expect_quiet("flush_prio2");

    // Reset mid-AND, then back-to-back ops with valid held.
    op    = 3'd2;
    rs1   = rand128();
    rs2   = rand128();
    rnd   = rand192();
    valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_quiet("rst_mid");
    @(posedge clk);
    #1;
    expect_quiet("rst_mid2");
    do_op(3'd1, rand128(), rand128(), rand192(), 0, 1, "b2b0");
    do_op(3'd2, rand128(), rand128(), rand192(), 1, 1, "b2b1");
    do_op(3'd5, rand128(), rand128(), rand192(), 1, 1, "b2b2");
    do_op(3'd3, rand128(), rand128(), rand192(), 1, 0, "b2b3");

    // Randomized sweep, 1000 ops per opcode.
    for (int i = 0; i < 8000; i++) begin
      do_op(3'(i % 8), rand128(), rand128(), rand192(), 0, 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
